// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge
// UART-driven MMIO initiator. Parses command frames handed over by a UART
// core through its sticky rx/tx flag handshake and issues 32-bit MMIO
// accesses on the data bus.
//   write frame : 'W' A3 A2 A1 A0 D3 D2 D1 D0  -> reply 'K'
//   read  frame : 'R' A3 A2 A1 A0              -> reply D3 D2 D1 D0
//   unknown cmd -> '?', parity error on any byte -> 'E'
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   rx_data/rx_flag/parity_error    received byte, sticky valid, parity status
//   rx_flag_clr                     one-cycle acknowledge of a consumed rx byte
//   tx_data/tx_send                 byte to send and one-cycle start pulse
//   tx_flag/tx_flag_clr             sticky tx-done flag and its acknowledge
//   data_mmio_addr                  MMIO address (holds after an access)
//   data_mmio_wr_addr_val           one-cycle write strobe
//   data_mmio_wr_data               MMIO write data
//   data_mmio_rd_data               MMIO read data (valid one cycle after addr)
//   busy                            high whenever the bridge is not idle
module uart_mmio_bridge #(
    parameter int ADDRESS_32_W    = 32,
    parameter int DATA_32_W       = 32,
    parameter int UART_DATA_WIDTH = 8,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [UART_DATA_WIDTH-1:0] rx_data,
    input  logic                       rx_flag,
    input  logic                       parity_error,
    output logic                       rx_flag_clr,
    output logic [UART_DATA_WIDTH-1:0] tx_data,
    output logic                       tx_send,
    input  logic                       tx_flag,
    output logic                       tx_flag_clr,
    output logic [ADDRESS_32_W-1:0]    data_mmio_addr,
    output logic                       data_mmio_wr_addr_val,
    output logic [DATA_32_W-1:0]       data_mmio_wr_data,
    input  logic [DATA_32_W-1:0]       data_mmio_rd_data,
    output logic                       busy
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_GET_ADDR   = 4'd1;
    localparam logic [3:0] S_GET_DATA   = 4'd2;
    localparam logic [3:0] S_RX_HOLD    = 4'd3;
    localparam logic [3:0] S_MMIO_WR    = 4'd4;
    localparam logic [3:0] S_MMIO_RD    = 4'd5;
    localparam logic [3:0] S_RD_CAPTURE = 4'd6;
    localparam logic [3:0] S_TX_SEND    = 4'd7;
    localparam logic [3:0] S_TX_WAIT    = 4'd8;
    localparam logic [3:0] S_TX_GAP     = 4'd9;

    localparam logic [7:0]  CMD_W     = 8'h57;
    localparam logic [7:0]  CMD_R     = 8'h52;
    localparam logic [7:0]  RSP_K     = 8'h4B;
    localparam logic [7:0]  RSP_E     = 8'h45;
    localparam logic [7:0]  RSP_Q     = 8'h3F;
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    logic [3:0]              state;
    logic [3:0]              after_hold;   // state to resume once RX_HOLD expires
    logic                    is_write;
    logic [2:0]              byte_cnt;
    logic [2:0]              tx_left;      // reply bytes still to transmit
    logic [31:0]             tmo_cnt;
    logic [ADDRESS_32_W-1:0] addr_sr;
    logic [DATA_32_W-1:0]    data_sr;
    logic [DATA_32_W-1:0]    reply;        // outgoing bytes, MSB first

    // busy is a pure decode of the state register
    assign busy = (state != S_IDLE);

    // Frame parser, MMIO sequencer and reply transmitter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= S_IDLE;
            after_hold            <= S_IDLE;
            is_write              <= 1'b0;
            byte_cnt              <= 3'd0;
            tx_left               <= 3'd0;
            tmo_cnt               <= 32'd0;
            addr_sr               <= '0;
            data_sr               <= '0;
            reply                 <= '0;
            rx_flag_clr           <= 1'b0;
            tx_data               <= '0;
            tx_send               <= 1'b0;
            tx_flag_clr           <= 1'b0;
            data_mmio_addr        <= '0;
            data_mmio_wr_addr_val <= 1'b0;
            data_mmio_wr_data     <= '0;
        end else begin
            // all handshake outputs are single-cycle pulses
            rx_flag_clr           <= 1'b0;
            tx_send               <= 1'b0;
            tx_flag_clr           <= 1'b0;
            data_mmio_wr_addr_val <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo_cnt  <= 32'd0;
                    byte_cnt <= 3'd0;
                    if (rx_flag) begin
                        rx_flag_clr <= 1'b1;
                        state       <= S_RX_HOLD;
                        if (parity_error) begin
                            reply      <= {RSP_E, {(DATA_32_W-8){1'b0}}};
                            tx_left    <= 3'd1;
                            after_hold <= S_TX_SEND;
                        end else if ((rx_data == CMD_W) || (rx_data == CMD_R)) begin
                            is_write   <= (rx_data == CMD_W);
                            after_hold <= S_GET_ADDR;
                        end else begin
                            reply      <= {RSP_Q, {(DATA_32_W-8){1'b0}}};
                            tx_left    <= 3'd1;
                            after_hold <= S_TX_SEND;
                        end
                    end
                end
                S_GET_ADDR, S_GET_DATA: begin
                    if (rx_flag) begin
                        rx_flag_clr <= 1'b1;
                        state       <= S_RX_HOLD;
                        tmo_cnt     <= 32'd0;
                        if (parity_error) begin
                            byte_cnt   <= 3'd0;
                            reply      <= {RSP_E, {(DATA_32_W-8){1'b0}}};
                            tx_left    <= 3'd1;
                            after_hold <= S_TX_SEND;
                        end else begin
                            if (state == S_GET_ADDR) begin
                                addr_sr <= {addr_sr[ADDRESS_32_W-UART_DATA_WIDTH-1:0], rx_data};
                            end else begin
                                data_sr <= {data_sr[DATA_32_W-UART_DATA_WIDTH-1:0], rx_data};
                            end
                            if (byte_cnt == 3'd3) begin
                                byte_cnt <= 3'd0;
                                if (state == S_GET_DATA) begin
                                    after_hold <= S_MMIO_WR;
                                end else if (is_write) begin
                                    after_hold <= S_GET_DATA;
                                end else begin
                                    after_hold <= S_MMIO_RD;
                                end
                            end else begin
                                byte_cnt   <= byte_cnt + 3'd1;
                                after_hold <= state;
                            end
                        end
                    end else if (tmo_cnt == TMO_LIMIT) begin
                        // stalled frame: drop it silently
                        state    <= S_IDLE;
                        tmo_cnt  <= 32'd0;
                        byte_cnt <= 3'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_RX_HOLD: begin
                    // rx_flag is ignored here while the UART core drops it;
                    // bus outputs are loaded so they are valid in MMIO_WR/RD
                    state <= after_hold;
                    if ((after_hold == S_MMIO_WR) || (after_hold == S_MMIO_RD)) begin
                        data_mmio_addr <= addr_sr;
                    end
                    if (after_hold == S_MMIO_WR) begin
                        data_mmio_wr_data     <= data_sr;
                        data_mmio_wr_addr_val <= 1'b1;
                    end
                end
                S_MMIO_WR: begin
                    reply   <= {RSP_K, {(DATA_32_W-8){1'b0}}};
                    tx_left <= 3'd1;
                    state   <= S_TX_SEND;
                end
                S_MMIO_RD: begin
                    state <= S_RD_CAPTURE;
                end
                S_RD_CAPTURE: begin
                    reply   <= data_mmio_rd_data;
                    tx_left <= 3'd4;
                    state   <= S_TX_SEND;
                end
                S_TX_SEND: begin
                    tx_data <= reply[DATA_32_W-1 -: UART_DATA_WIDTH];
                    tx_send <= 1'b1;
                    state   <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (tx_flag) begin
                        tx_flag_clr <= 1'b1;
                        state       <= S_TX_GAP;
                    end
                end
                S_TX_GAP: begin
                    // one idle cycle so the UART core sees tx_flag clear
                    reply   <= reply << UART_DATA_WIDTH;
                    tx_left <= tx_left - 3'd1;
                    if (tx_left == 3'd1) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_TX_SEND;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
